// File: rtl/trdb_stream_unalign8.sv
// Trace stream unaligner: strips fill bytes from a 32-bit word stream and
// rebuilds length-prefixed packets into a parallel payload plus byte count.
module trdb_stream_unalign8 #(
    parameter int unsigned MAX_PAYLOAD_BYTES = 16,
    parameter int unsigned ID                = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [31:0]                    data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic                           flush_i,
    output logic                           flush_confirm_o,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] packet_bits_o,
    output logic [7:0]                     packet_bytes_o,
    output logic                           packet_valid_o,
    input  logic                           packet_ready_i,
    output logic                           error_o
);

    localparam int unsigned PAYLOAD_W = 8 * MAX_PAYLOAD_BYTES;
    localparam logic [7:0]  MAX_HDR   = 8'(MAX_PAYLOAD_BYTES);

    // Header byte and byte count are 8 bits wide, so the payload limit must fit.
    if (MAX_PAYLOAD_BYTES < 1 || MAX_PAYLOAD_BYTES > 255) begin : g_bad_max
        $error("trdb_stream_unalign8: MAX_PAYLOAD_BYTES must be 1..255");
    end

    // Instance id is reserved for multi-core tracing and has no logic attached.
    if (ID == 0) begin : g_id_zero
    end

    typedef enum logic [1:0] {ST_HDR, ST_PAY, ST_OUT} state_e;

    state_e                 state_q;
    logic [3:0][7:0]        buf_q;
    logic [2:0]             buf_cnt_q;
    logic [1:0]             rd_ptr_q;
    logic [7:0]             rem_q;
    logic [7:0]             off_q;

    logic [7:0]             cur_byte_c;
    logic [2:0]             take_c;
    logic [PAYLOAD_W-1:0]   pay_next_c;

    assign cur_byte_c = buf_q[rd_ptr_q];
    assign take_c     = (rem_q < 8'(buf_cnt_q)) ? 3'(rem_q) : buf_cnt_q;
    assign ready_o    = (buf_cnt_q == 3'd0) && !flush_i;

    // Scatter the bytes taken this cycle into the payload at the write offset.
    always_comb begin
        pay_next_c = packet_bits_o;
        for (int k = 0; k < int'(MAX_PAYLOAD_BYTES); k++) begin
            if ((8'(k) >= off_q) && (8'(k) < (off_q + 8'(take_c)))) begin
                pay_next_c[8*k +: 8] = buf_q[2'(rd_ptr_q + 2'(8'(k) - off_q))];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_HDR;
            buf_q           <= '0;
            buf_cnt_q       <= 3'd0;
            rd_ptr_q        <= 2'd0;
            rem_q           <= 8'd0;
            off_q           <= 8'd0;
            packet_bits_o   <= '0;
            packet_bytes_o  <= 8'd0;
            packet_valid_o  <= 1'b0;
            error_o         <= 1'b0;
            flush_confirm_o <= 1'b0;
        end else begin
            error_o         <= 1'b0;
            flush_confirm_o <= flush_i;
            if (flush_i) begin
                state_q        <= ST_HDR;
                buf_cnt_q      <= 3'd0;
                rd_ptr_q       <= 2'd0;
                rem_q          <= 8'd0;
                off_q          <= 8'd0;
                packet_bits_o  <= '0;
                packet_bytes_o <= 8'd0;
                packet_valid_o <= 1'b0;
            end else begin
                // Only loads an empty buffer, so it never collides with consumption.
                if (valid_i && ready_o) begin
                    buf_q     <= data_i;
                    buf_cnt_q <= 3'd4;
                    rd_ptr_q  <= 2'd0;
                end
                case (state_q)
                    ST_HDR: begin
                        if (buf_cnt_q != 3'd0) begin
                            buf_cnt_q <= buf_cnt_q - 3'd1;
                            rd_ptr_q  <= rd_ptr_q + 2'd1;
                            if (cur_byte_c > MAX_HDR) begin
                                error_o <= 1'b1;
                            end else if (cur_byte_c != 8'd0) begin
                                rem_q          <= cur_byte_c;
                                off_q          <= 8'd0;
                                packet_bytes_o <= cur_byte_c;
                                state_q        <= ST_PAY;
                            end
                        end
                    end
                    ST_PAY: begin
                        if (buf_cnt_q != 3'd0) begin
                            buf_cnt_q     <= buf_cnt_q - take_c;
                            rd_ptr_q      <= rd_ptr_q + take_c[1:0];
                            rem_q         <= rem_q - 8'(take_c);
                            off_q         <= off_q + 8'(take_c);
                            packet_bits_o <= pay_next_c;
                            if (rem_q == 8'(take_c)) begin
                                state_q        <= ST_OUT;
                                packet_valid_o <= 1'b1;
                            end
                        end
                    end
                    ST_OUT: begin
                        if (packet_ready_i) begin
                            state_q        <= ST_HDR;
                            packet_valid_o <= 1'b0;
                            packet_bits_o  <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_HDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/trdb_stream_unalign8.md
# trdb_stream_unalign8

Receive-side counterpart of the trace stream aligner. It takes the 32-bit word stream of byte-aligned, length-prefixed trace packets, strips zero fill bytes, and reassembles each packet into a parallel payload plus byte count. It sits between the trace memory/DMA read path and the software-visible packet decoder model in the hardware testbench and debug bridge.

## Interface
- `MAX_PAYLOAD_BYTES`, default 16. Largest legal payload in bytes; sets `packet_bits_o` width to `8*MAX_PAYLOAD_BYTES`.
- `ID`, default 1. Instance identifier; reserved for multi-core tracing, no functional effect.
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `data_i` input 32: stream word; byte 0 is `[7:0]` and is consumed first.
- `valid_i` input 1: `data_i` valid.
- `ready_o` output 1: word accepted on a cycle with `valid_i && ready_o`.
- `flush_i` input 1: discard all buffered state.
- `flush_confirm_o` output 1: one-cycle pulse, cycle after `flush_i`.
- `packet_bits_o` output 8*MAX_PAYLOAD_BYTES: payload; payload byte k at `[8k+:8]`, unused bytes zero.
- `packet_bytes_o` output 8: payload byte count, 1..MAX_PAYLOAD_BYTES.
- `packet_valid_o` output 1: packet available.
- `packet_ready_i` input 1: packet consumed on `packet_valid_o && packet_ready_i`.
- `error_o` output 1: one-cycle pulse on illegal header.

## Operation
- Word buffer: 32-bit register plus byte count `buf_cnt` (0..4) and read pointer. `ready_o = (buf_cnt == 0) && !flush_i`. Accepted word loads `buf_cnt = 4`, pointer 0; processing starts next cycle.
- Byte framing: header byte = payload byte count. Header 0 = fill byte, dropped. Header > MAX_PAYLOAD_BYTES = illegal: byte dropped, `error_o` pulses, state stays HDR (resync on next byte).
- FSM states HDR, PAY, OUT; reset state HDR.
- HDR: if `buf_cnt > 0`, consume exactly one byte. Legal nonzero header: `rem = hdr`, `packet_bytes_o = hdr`, write offset 0, go PAY.
- PAY: if `buf_cnt > 0`, consume `n = min(rem, buf_cnt)` bytes in one cycle, place them at payload offset, `rem -= n`, offset += n; when `rem` reaches 0 go OUT.
- OUT: `packet_valid_o = 1`; no bytes consumed; buffer may still refill if empty. On `packet_ready_i`: go HDR, clear `packet_bits_o` to zero.
- `packet_bits_o`/`packet_bytes_o` stable while `packet_valid_o` high.
- `flush_i` (highest priority, over word accept and packet handshake): next cycle `buf_cnt = 0`, state HDR, `rem = 0`, `packet_valid_o = 0`, `packet_bits_o = 0`, `packet_bytes_o = 0`, `flush_confirm_o = 1`. A pending packet is dropped.
- Widths: `rem` and offset 8 bits; `n` computed in 3 bits; no wrap possible given header check.

## Timing
- Reset values: `ready_o = 1`, `packet_valid_o = 0`, `packet_bits_o = 0`, `packet_bytes_o = 0`, `error_o = 0`, `flush_confirm_o = 0`.
- Reset asserted mid-packet: all state cleared immediately, partial packet lost, no `error_o`.
- Single-word packet: word accepted cycle 0, header consumed cycle 1, payload cycle 2, `packet_valid_o` high cycle 3.
- Throughput: at most one header byte per cycle; payload up to 4 bytes per cycle.
- `ready_o` rises the cycle after the last buffered byte is consumed.
- Header and payload end exactly at word end: `ready_o` high in same cycle OUT is entered.
- `error_o` asserted the cycle after the illegal header is consumed, exactly one cycle per bad byte.

## Test plan
- Reset, word 0x00BBAA02 -> cycle 3 `packet_valid_o = 1`, `packet_bits_o = 0xBBAA`, `packet_bytes_o = 2`; after accept, fill byte dropped, `ready_o = 1` one cycle later, no packet.
- Words 0x33221106, 0x00665544 -> single packet `packet_bits_o = 0x665544332211`, `packet_bytes_o = 6`; trailing 0x00 dropped.
- `packet_ready_i = 0` for 10 cycles with next word pending -> outputs held stable, next word accepted once buffer empty, no bytes lost; second packet correct after release.
- MAX_PAYLOAD_BYTES = 16, word 0xCCCC0120 -> `error_o` one pulse, then header 0x01 gives packet 0xCC, bytes 1; remaining 0xCC treated as header -> second `error_o`.
- Flush mid-packet (header 6, 3 bytes received) -> next cycle `flush_confirm_o = 1`, `ready_o = 1`, no `packet_valid_o`; following word 0x0000AA01 yields packet 0xAA, bytes 1.
- Assert `rst_i` asynchronously in PAY state -> all outputs at reset values before next clock edge.
